core_sequencer: RTL
===================

Name: core_sequencer

Overview:
Multi-cycle control FSM for the single-issue core. Sequences fetch -> decode -> execute -> memory -> writeback around the registered decoder, ALU, register file and data memory. Owns the PC, the instruction register and the retired-instruction counter. Traps on illegal opcodes and on memory-handshake timeouts.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
TIMEOUT, 8'd255, maximum cycles to wait for imem_ack/dmem_ack before trapping

Ports:
clk  input  1  system clock, all state on posedge
rst_n  input  1  asynchronous active-low reset
run  input  1  level; while 0 the FSM parks in IDLE after the current instruction retires
imem_req  output  1  instruction fetch request
imem_addr  output  32  fetch address (= pc)
imem_rdata  input  32  fetched instruction, valid with imem_ack
imem_ack  input  1  fetch complete
ir  output  32  instruction register, feeds the decoder instr input
alu_op  input  4  decoder class code: 1-10 ALU/ADDI, 11 LW, 12 SW, 0/13-15 illegal
alu_en  output  1  one-cycle execute strobe to the ALU
dmem_req  output  1  data memory request
dmem_we  output  1  1 = store (SW), 0 = load (LW)
dmem_ack  input  1  data access complete
rf_we  output  1  register-file write strobe, one cycle
pc  output  32  current program counter
retired  output  32  count of retired instructions
busy  output  1  1 in every state except IDLE and TRAP
trap  output  1  sticky trap flag
trap_cause  output  2  0 none, 1 illegal opcode, 2 imem timeout, 3 dmem timeout

Behaviour:
- Reset (async, rst_n=0): state=IDLE, pc=RESET_PC, ir=0, retired=0, trap=0, trap_cause=0, wait counter=0, all strobes/requests=0. Deassertion takes effect at the next posedge.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP.
- IDLE: run=1 -> FETCH; otherwise stay.
- FETCH: imem_req=1, imem_addr=pc, held constant until ack. On imem_ack: ir<=imem_rdata, -> DECODE. Wait counter increments each cycle without ack; counter reaching TIMEOUT with no ack -> TRAP, cause 2. Ack in the same cycle the counter hits TIMEOUT wins: no trap.
- DECODE: single wait cycle, because the decoder registers on posedge. alu_op is sampled at the end of this cycle's successor, i.e. in EXEC.
- EXEC: alu_en=1 for exactly one cycle. alu_op 1-10 -> WB. 11 or 12 -> MEM. Any other value -> TRAP, cause 1, with no rf_we, pc unchanged.
- MEM: dmem_req=1, dmem_we=(alu_op==12). Wait on dmem_ack with the same timeout rule; timeout -> TRAP, cause 3. On ack: LW -> WB; SW retires directly (no rf_we) and goes to the retire step.
- WB: rf_we=1 for one cycle, then retire.
- Retire (on the WB->next or MEM(SW)->next transition): pc<=pc+4 (mod 2^32, wraps to 0), retired<=retired+1 (wraps at 2^32). Next state: FETCH if run=1, else IDLE.
- Wait counter clears on every state entry.
- TRAP: trap=1, all strobes 0, pc holds the faulting instruction's address; exit only via rst_n.
- Minimum latency per instruction, zero-wait memories: ALU = 4 cycles (FETCH, DECODE, EXEC, WB); LW = 5; SW = 4.
- run deasserted mid-instruction: the instruction completes normally, then IDLE.
- Reset mid-access: requests drop immediately and asynchronously; a late ack after reset is ignored.

Test Plan:
- ADD at 0x0, zero-wait memories, run=1 -> imem_req cycle 1, alu_en cycle 3, rf_we cycle 4; pc=0x4, retired=1.
- LW then SW, dmem_ack after 3 waits -> dmem_we=0 then 1; rf_we only for LW; retired=2, pc=0x8.
- Instruction with opcode 0x7F -> trap=1, trap_cause=1, pc holds 0x0, no rf_we/dmem_req; stays in TRAP until rst_n.
- imem_ack withheld, TIMEOUT=4 -> trap_cause=2 exactly 4 cycles after FETCH entry; ack on cycle 4 instead -> no trap.
- run dropped during EXEC of an ADDI -> rf_we still pulses, pc+4, then IDLE with busy=0; run=1 resumes fetch at the new pc.
- rst_n asserted mid-MEM -> dmem_req=0 immediately, pc=RESET_PC, retired=0; pc=0xFFFF_FFFC retiring wraps pc to 0x0.

Source files
------------

// File: rtl/core_sequencer.sv
// ---------------------------------------------------------------------------------------------
// core_sequencer
//   Multi-cycle control FSM for the single-issue core. Each instruction walks through
//   FETCH -> DECODE -> EXEC -> [MEM] -> [WB] and then retires. The block owns the program
//   counter, the instruction register and the retired-instruction counter, and traps on
//   illegal opcodes or on instruction/data handshakes that never complete.
//
// Ports
//   clk, rst_n        clock (posedge) and asynchronous active-low reset
//   run               level; when low the FSM parks in IDLE once the current instruction retires
//   imem_req/addr     instruction fetch request, address = pc
//   imem_rdata/ack    fetched instruction and its completion strobe
//   ir                instruction register, drives the registered decoder
//   alu_op            decoder class: 1-10 ALU/ADDI, 11 LW, 12 SW, anything else illegal
//   alu_en            one-cycle execute strobe
//   dmem_req/we/ack   data memory handshake, we=1 for a store
//   rf_we             one-cycle register-file write strobe
//   pc, retired       program counter and retired-instruction count
//   busy              high in every state except IDLE and TRAP
//   trap, trap_cause  sticky trap flag and cause (1 illegal, 2 imem timeout, 3 dmem timeout)
// ---------------------------------------------------------------------------------------------
module core_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [7:0]  TIMEOUT  = 8'd255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic [31:0] ir,
    input  logic [3:0]  alu_op,
    output logic        alu_en,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    output logic        rf_we,
    output logic [31:0] pc,
    output logic [31:0] retired,
    output logic        busy,
    output logic        trap,
    output logic [1:0]  trap_cause
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StExec,
        StMem,
        StWb,
        StTrap
    } state_e;

    localparam logic [1:0] CauseIllegal = 2'd1;
    localparam logic [1:0] CauseImem    = 2'd2;
    localparam logic [1:0] CauseDmem    = 2'd3;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] retired_q, retired_d;
    logic [1:0]  cause_q, cause_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        is_store_q, is_store_d;

    logic        wait_expired;
    logic        retire;
    logic        op_alu;
    logic        op_mem;

    // The current cycle is the TIMEOUT-th one spent waiting; an ack in this same cycle still wins
    // because the ack branches are tested first below.
    assign wait_expired = ({1'b0, wait_cnt_q} + 9'd1) == {1'b0, TIMEOUT};

    assign op_alu = (alu_op >= 4'd1) && (alu_op <= 4'd10);
    assign op_mem = (alu_op == 4'd11) || (alu_op == 4'd12);

    // State register (all architectural state lives here).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            pc_q       <= RESET_PC;
            ir_q       <= '0;
            retired_q  <= '0;
            cause_q    <= '0;
            wait_cnt_q <= '0;
            is_store_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            retired_q  <= retired_d;
            cause_q    <= cause_d;
            wait_cnt_q <= wait_cnt_d;
            is_store_q <= is_store_d;
        end
    end

    // Next-state logic. The wait counter defaults to zero, so it clears on every state entry and
    // only counts up while a handshake is pending.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        retired_d  = retired_q;
        cause_d    = cause_q;
        wait_cnt_d = '0;
        is_store_d = is_store_q;
        retire     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (run) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    state_d = StDecode;
                end else if (wait_expired) begin
                    state_d = StTrap;
                    cause_d = CauseImem;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            // One bubble while the decoder registers ir; alu_op is valid in EXEC.
            StDecode: begin
                state_d = StExec;
            end
            StExec: begin
                if (op_alu) begin
                    state_d = StWb;
                end else if (op_mem) begin
                    state_d    = StMem;
                    is_store_d = (alu_op == 4'd12);
                end else begin
                    state_d = StTrap;
                    cause_d = CauseIllegal;
                end
            end
            StMem: begin
                if (dmem_ack) begin
                    if (is_store_q) begin
                        retire = 1'b1;
                    end else begin
                        state_d = StWb;
                    end
                end else if (wait_expired) begin
                    state_d = StTrap;
                    cause_d = CauseDmem;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            StWb: begin
                retire = 1'b1;
            end
            StTrap: begin
                state_d = StTrap;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Retirement is shared by WB and by a completed store.
        if (retire) begin
            pc_d      = pc_q + 32'd4;
            retired_d = retired_q + 32'd1;
            state_d   = run ? StFetch : StIdle;
        end
    end

    // Outputs are purely a function of the current state so that an asynchronous reset drops
    // every request immediately.
    always_comb begin
        imem_req = 1'b0;
        alu_en   = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        rf_we    = 1'b0;
        busy     = 1'b1;
        trap     = 1'b0;

        unique case (state_q)
            StIdle: begin
                busy = 1'b0;
            end
            StFetch: begin
                imem_req = 1'b1;
            end
            StDecode: begin
                busy = 1'b1;
            end
            StExec: begin
                alu_en = 1'b1;
            end
            StMem: begin
                dmem_req = 1'b1;
                dmem_we  = is_store_q;
            end
            StWb: begin
                rf_we = 1'b1;
            end
            StTrap: begin
                busy = 1'b0;
                trap = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign imem_addr  = pc_q;
    assign pc         = pc_q;
    assign ir         = ir_q;
    assign retired    = retired_q;
    assign trap_cause = cause_q;

endmodule
